// File: rtl/life_pkg.sv
// Shared Game-of-Life definitions: grid geometry, cell indexing and scan-out state encoding.
package life_pkg;

    localparam int LIFE_ROWS = 8;
    localparam int LIFE_COLS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } scan_state_t;

    // Flat bit position of cell (r,c); the grid is stored row-major, row 0 in the low bits.
    function automatic int unsigned idx(input int unsigned r,
                                        input int unsigned c,
                                        input int unsigned cols = LIFE_COLS);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones instead of wrapping.
module life_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/life_grid_scanout.sv
// Snapshots the life grid on each generation tick and streams it out one row per
// valid/ready beat, row 0 first, counting generations that arrive while a frame is in flight.
module life_grid_scanout
    import life_pkg::*;
#(
    parameter int ROWS  = LIFE_ROWS,
    parameter int COLS  = LIFE_COLS,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    _rst,
    input  logic [ROWS*COLS-1:0]    grid_in,
    input  logic                    gen_tick,
    output logic [COLS-1:0]         row_data,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    frame_start,
    output logic                    frame_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam int RW = $clog2(ROWS);
    localparam int BW = $clog2(ROWS * COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    scan_state_t           r_state;
    scan_state_t           w_state_nxt;
    logic [ROWS*COLS-1:0]  r_snap;
    logic [ROWS*COLS-1:0]  w_snap_nxt;
    logic [RW-1:0]         r_row;
    logic [RW-1:0]         w_row_nxt;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_drop;

    assign w_hs   = (r_state == SEND) && row_ready;
    assign w_last = (r_row == LAST_ROW);

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state <= IDLE;
            r_snap  <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_snap  <= w_snap_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_row_nxt   = r_row;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (gen_tick) begin
                    w_state_nxt = SEND;
                    w_snap_nxt  = grid_in;
                    w_row_nxt   = '0;
                end
            end
            SEND: begin
                // A tick landing on the final handshake chains straight into the next frame.
                if (w_hs && w_last) begin
                    w_row_nxt = '0;
                    if (gen_tick) begin
                        w_snap_nxt = grid_in;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_row_nxt = r_row + 1'b1;
                    end
                    w_drop = gen_tick;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        row_data = '0;
        for (int c = 0; c < COLS; c++) begin
            row_data[c] = r_snap[BW'(idx(32'(r_row), c, COLS))];
        end
    end

    assign row_valid   = (r_state == SEND);
    assign busy        = (r_state == SEND);
    assign row_idx     = r_row;
    assign frame_start = row_valid && (r_row == '0);
    assign frame_last  = row_valid && w_last;

    life_sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .i_clk   (clk),
        .i_rst_n (_rst),
        .i_inc   (w_drop),
        .o_cnt   (drop_cnt)
    );

endmodule
